// File: rtl/core_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// core_prefetch_queue_if
// Handshake and data bundle between the fetch stage / decode control and the
// instruction prefetch queue.
//   master : the side that drives fetch results and decode control
//   slave  : the prefetch queue itself
// ---------------------------------------------------------------------------
interface core_prefetch_queue_if;

    // Decode-side control
    logic        stall;       // decode not accepting this cycle
    logic        flush;       // discard queue contents, restart at head
    logic [29:0] head;        // restart word-address PC, valid with flush

    // Fetch-side input
    logic        fetched;     // fetch_data valid this cycle
    logic [31:0] fetch_data;  // fetched instruction word

    // Queue outputs
    logic        fetch;       // queue can absorb one more in-flight word
    logic [31:0] insn;        // instruction to decode
    logic [29:0] insn_pc;     // word PC of insn
    logic        nop;         // insn is a bubble

    modport master (
        output stall,
        output flush,
        output head,
        output fetched,
        output fetch_data,
        input  fetch,
        input  insn,
        input  insn_pc,
        input  nop
    );

    modport slave (
        input  stall,
        input  flush,
        input  head,
        input  fetched,
        input  fetch_data,
        output fetch,
        output insn,
        output insn_pc,
        output nop
    );

endinterface : core_prefetch_queue_if

// File: rtl/core_prefetch_queue.sv
// ---------------------------------------------------------------------------
// core_prefetch_queue
// Instruction prefetch buffer between fetch and decode. Words arrive in
// program order; the queue tracks each word's PC and presents one
// instruction per cycle through registered outputs, issuing a nop bubble
// whenever it has nothing to give. A flush empties the queue and restarts
// PC tracking at a new head.
//
// Optional build macro:
//   CORE_PREFETCH_BYPASS_EN - when the queue is empty and decode is not
//   stalled, a freshly fetched word is loaded straight into the output
//   registers (1-cycle latency) instead of passing through the storage
//   array (2-cycle latency).
// ---------------------------------------------------------------------------

// Protocol checker, kept apart from the datapath so it never reaches
// synthesis netlists as logic.
module core_prefetch_queue_chk #(
    parameter int          ORDER    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetched,
    input  logic             flush,
    input  logic [ORDER:0]   count,
    input  logic             nop,
    input  logic [31:0]      insn
);

    localparam int           DEPTH     = 1 << ORDER;
    localparam logic [ORDER:0] CNT_DEPTH = (ORDER+1)'(DEPTH);

    // A word pushed into a completely full queue is lost.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(fetched && !flush && (count == CNT_DEPTH)))
        else $error("prefetch queue: enqueue while full, word dropped");

    // Occupancy can never exceed the storage depth.
    a_count_range : assert property (@(posedge clk) disable iff (rst)
        (count <= CNT_DEPTH))
        else $error("prefetch queue: occupancy out of range");

    // A bubble always carries the configured nop encoding.
    a_nop_word : assert property (@(posedge clk) disable iff (rst)
        (nop |-> (insn == NOP_WORD)))
        else $error("prefetch queue: bubble with non-nop instruction word");

endmodule : core_prefetch_queue_chk


module core_prefetch_queue #(
    parameter int          ORDER    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    core_prefetch_queue_if.slave  bus
);

    localparam int               DEPTH     = 1 << ORDER;
    localparam logic [ORDER:0]   CNT_ZERO  = (ORDER+1)'(0);
    localparam logic [ORDER:0]   CNT_ONE   = (ORDER+1)'(1);
    localparam logic [ORDER:0]   CNT_DEPTH = (ORDER+1)'(DEPTH);
    // One slot is held back for the word that may already be in flight.
    localparam logic [ORDER:0]   CNT_RESV  = (ORDER+1)'(DEPTH - 1);
    localparam logic [ORDER-1:0] PTR_ZERO  = ORDER'(0);
    localparam logic [ORDER-1:0] PTR_ONE   = ORDER'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_mem_data [DEPTH];
    logic [29:0]      r_mem_pc   [DEPTH];
    logic [ORDER-1:0] r_rd_ptr;
    logic [ORDER-1:0] r_wr_ptr;
    logic [ORDER:0]   r_count;
    logic [29:0]      r_tail_pc;

    logic [31:0]      r_insn;
    logic [29:0]      r_insn_pc;
    logic             r_nop;

    // ------------------------------------------------------------------
    // Per-cycle decisions
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_enq;
    logic w_deq;
    logic w_fetch;

    // Classify this cycle: bypass, enqueue, dequeue and the fetch credit.
    always_comb begin
        w_empty  = 1'b0;
        w_full   = 1'b0;
        w_bypass = 1'b0;
        w_enq    = 1'b0;
        w_deq    = 1'b0;
        w_fetch  = 1'b0;

        if (r_count == CNT_ZERO) begin
            w_empty = 1'b1;
        end else begin
            w_empty = 1'b0;
        end

        if (r_count == CNT_DEPTH) begin
            w_full = 1'b1;
        end else begin
            w_full = 1'b0;
        end

`ifdef CORE_PREFETCH_BYPASS_EN
        // Empty queue and a ready decoder: the word skips storage.
        if (w_empty && bus.fetched && !bus.stall && !bus.flush) begin
            w_bypass = 1'b1;
        end else begin
            w_bypass = 1'b0;
        end
`else
        w_bypass = 1'b0;
`endif

        // Flush drops a same-cycle word; a full queue drops it too.
        if (bus.fetched && !bus.flush && !w_full && !w_bypass) begin
            w_enq = 1'b1;
        end else begin
            w_enq = 1'b0;
        end

        if (!bus.stall && !bus.flush && !w_empty) begin
            w_deq = 1'b1;
        end else begin
            w_deq = 1'b0;
        end

        if (r_count < CNT_RESV) begin
            w_fetch = 1'b1;
        end else begin
            w_fetch = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage array write port
    // ------------------------------------------------------------------

    // Capture each enqueued word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= 32'h0000_0000;
                r_mem_pc[i]   <= 30'h0000_0000;
            end
        end else if (w_enq) begin
            r_mem_data[r_wr_ptr] <= bus.fetch_data;
            r_mem_pc[r_wr_ptr]   <= r_tail_pc;
        end else begin
            r_mem_data[r_wr_ptr] <= r_mem_data[r_wr_ptr];
            r_mem_pc[r_wr_ptr]   <= r_mem_pc[r_wr_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and PC tracking
    // ------------------------------------------------------------------

    // Advance pointers/count on enqueue and dequeue; flush restarts at head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= PTR_ZERO;
            r_wr_ptr  <= PTR_ZERO;
            r_count   <= CNT_ZERO;
            r_tail_pc <= 30'h0000_0000;
        end else if (bus.flush) begin
            r_rd_ptr  <= PTR_ZERO;
            r_wr_ptr  <= PTR_ZERO;
            r_count   <= CNT_ZERO;
            r_tail_pc <= bus.head;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end

            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end

            // Every accepted word consumes a PC, bypassed or queued.
            if (w_enq || w_bypass) begin
                r_tail_pc <= r_tail_pc + 30'd1;
            end else begin
                r_tail_pc <= r_tail_pc;
            end

            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered decode-side outputs
    // ------------------------------------------------------------------

    // Load the next instruction, a bypassed word, or a bubble into decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_insn    <= NOP_WORD;
            r_insn_pc <= 30'h0000_0000;
            r_nop     <= 1'b1;
        end else if (bus.flush) begin
            r_insn    <= NOP_WORD;
            r_insn_pc <= bus.head;
            r_nop     <= 1'b1;
        end else if (bus.stall) begin
            r_insn    <= r_insn;
            r_insn_pc <= r_insn_pc;
            r_nop     <= r_nop;
        end else if (w_bypass) begin
            r_insn    <= bus.fetch_data;
            r_insn_pc <= r_tail_pc;
            r_nop     <= 1'b0;
        end else if (!w_empty) begin
            r_insn    <= r_mem_data[r_rd_ptr];
            r_insn_pc <= r_mem_pc[r_rd_ptr];
            r_nop     <= 1'b0;
        end else begin
            // Nothing to give: bubble, keep the last PC for reference.
            r_insn    <= NOP_WORD;
            r_insn_pc <= r_insn_pc;
            r_nop     <= 1'b1;
        end
    end

    assign bus.fetch   = w_fetch;
    assign bus.insn    = r_insn;
    assign bus.insn_pc = r_insn_pc;
    assign bus.nop     = r_nop;

    core_prefetch_queue_chk #(
        .ORDER    (ORDER),
        .NOP_WORD (NOP_WORD)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .fetched (bus.fetched),
        .flush   (bus.flush),
        .count   (r_count),
        .nop     (r_nop),
        .insn    (r_insn)
    );

endmodule : core_prefetch_queue

// File: tb/tb_core_prefetch_queue.sv
// ---------------------------------------------------------------------------
// tb_core_prefetch_queue
// Directed self-checking bench for core_prefetch_queue (ORDER=2, DEPTH=4).
// Expected latency follows CORE_PREFETCH_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_core_prefetch_queue;

`ifdef CORE_PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    core_prefetch_queue_if bus ();

    core_prefetch_queue #(
        .ORDER    (2),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [29:0] h);
        bus.flush = 1'b1;
        bus.head  = h;
        tick();
        bus.flush = 1'b0;
    endtask

    logic [31:0] a_words [4];
    logic [29:0] exp_pc;
    int          sent;
    int          got;
    logic        stall_was;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        a_words[0]     = 32'hA000_0000;
        a_words[1]     = 32'hA111_1111;
        a_words[2]     = 32'hA222_2222;
        a_words[3]     = 32'hA333_3333;
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.head       = 30'h0;
        bus.fetched    = 1'b0;
        bus.fetch_data = 32'h0;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_insn",  bus.insn,    32'h0);
        check_eq("rst_nop",   bus.nop,     1'b1);
        check_eq("rst_pc",    bus.insn_pc, 30'h0);
        check_eq("rst_fetch", bus.fetch,   1'b1);

        // ---------------- flush and stream ----------------
        do_flush(30'h100);
        check_eq("flush_nop", bus.nop,     1'b1);
        check_eq("flush_pc",  bus.insn_pc, 30'h100);
        for (int t = 1; t <= 6; t++) begin
            if (t <= 4) begin
                bus.fetched    = 1'b1;
                bus.fetch_data = a_words[t-1];
            end else begin
                bus.fetched    = 1'b0;
                bus.fetch_data = 32'h0;
            end
            tick();
            if ((t - LAT) >= 0 && (t - LAT) < 4) begin
                check_eq("stream_insn", bus.insn,    a_words[t-LAT]);
                check_eq("stream_pc",   bus.insn_pc, 30'h100 + 30'(t - LAT));
                check_eq("stream_nop",  bus.nop,     1'b0);
            end else begin
                check_eq("stream_bubble_nop",  bus.nop,  1'b1);
                check_eq("stream_bubble_insn", bus.insn, 32'h0);
            end
        end
        check_eq("empty_pc_hold", bus.insn_pc, 30'h103);

        // ---------------- fill under stall ----------------
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetched    = 1'b1;
            bus.fetch_data = 32'hC000_0000 + 32'(i);
            tick();
            check_eq("fill_fetch", bus.fetch, (i < 2) ? 1'b1 : 1'b0);
            check_eq("fill_hold_nop", bus.nop, 1'b1);
        end
        bus.fetched = 1'b0;
        bus.stall   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("drain_insn", bus.insn,    32'hC000_0000 + 32'(i));
            check_eq("drain_pc",   bus.insn_pc, 30'h104 + 30'(i));
            check_eq("drain_nop",  bus.nop,     1'b0);
        end
        tick();
        check_eq("drain_end_nop",   bus.nop,     1'b1);
        check_eq("drain_end_insn",  bus.insn,    32'h0);
        check_eq("drain_end_pc",    bus.insn_pc, 30'h106);
        check_eq("drain_end_fetch", bus.fetch,   1'b1);

        // ---------------- flush of a full queue ----------------
        bus.stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                check_eq("full_prepush_fetch", bus.fetch, 1'b0);
            end
            bus.fetched    = 1'b1;
            bus.fetch_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        check_eq("full_fetch", bus.fetch, 1'b0);
        bus.flush      = 1'b1;
        bus.head       = 30'h2000;
        bus.fetched    = 1'b1;
        bus.fetch_data = 32'hDEAD_BEEF;
        tick();
        bus.flush   = 1'b0;
        bus.fetched = 1'b0;
        bus.stall   = 1'b0;
        check_eq("fflush_nop",   bus.nop,     1'b1);
        check_eq("fflush_insn",  bus.insn,    32'h0);
        check_eq("fflush_pc",    bus.insn_pc, 30'h2000);
        check_eq("fflush_fetch", bus.fetch,   1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("fflush_idle_nop", bus.nop,     1'b1);
            check_eq("fflush_idle_pc",  bus.insn_pc, 30'h2000);
        end
        bus.fetched    = 1'b1;
        bus.fetch_data = 32'hE000_0000;
        tick();
        bus.fetched = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check_eq("post_flush_insn", bus.insn,    32'hE000_0000);
        check_eq("post_flush_pc",   bus.insn_pc, 30'h2000);
        check_eq("post_flush_nop",  bus.nop,     1'b0);
        tick();
        check_eq("post_flush_bubble", bus.nop, 1'b1);

        // ---------------- pointer and PC wrap ----------------
        do_flush(30'h3FFF_FFFE);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            bus.stall = (((cyc / 2) % 2) == 1);
            if (sent < 10 && bus.fetch) begin
                bus.fetched    = 1'b1;
                bus.fetch_data = 32'hC0DE_0000 + 32'(sent);
                sent++;
            end else begin
                bus.fetched = 1'b0;
            end
            stall_was = bus.stall;
            tick();
            if (!stall_was && !bus.nop) begin
                exp_pc = 30'h3FFF_FFFE + 30'(got);
                check_eq("wrap_insn", bus.insn,    32'hC0DE_0000 + 32'(got));
                check_eq("wrap_pc",   bus.insn_pc, exp_pc);
                got++;
            end
        end
        bus.fetched = 1'b0;
        bus.stall   = 1'b0;
        check_eq("wrap_count", 64'(got), 64'd10);

        // ---------------- stall on a real instruction ----------------
        do_flush(30'h500);
        bus.fetched    = 1'b1;
        bus.fetch_data = 32'hB000_000B;
        tick();
        bus.fetched = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check_eq("stallB_insn", bus.insn, 32'hB000_000B);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                bus.fetched    = 1'b1;
                bus.fetch_data = 32'hF100_0001;
            end else begin
                bus.fetched = 1'b0;
            end
            tick();
            check_eq("stallB_hold_insn", bus.insn,    32'hB000_000B);
            check_eq("stallB_hold_pc",   bus.insn_pc, 30'h500);
            check_eq("stallB_hold_nop",  bus.nop,     1'b0);
        end
        bus.fetched = 1'b0;
        bus.stall   = 1'b0;
        tick();
        check_eq("stallB_next_insn", bus.insn,    32'hF100_0001);
        check_eq("stallB_next_pc",   bus.insn_pc, 30'h501);
        tick();
        check_eq("stallB_end_nop", bus.nop, 1'b1);

        // ---------------- reset mid-stream ----------------
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.fetched    = 1'b1;
            bus.fetch_data = 32'h6000_0000 + 32'(i);
            tick();
        end
        rst            = 1'b1;
        bus.flush      = 1'b1;
        bus.head       = 30'h777;
        bus.fetched    = 1'b1;
        bus.stall      = 1'b0;
        tick();
        rst         = 1'b0;
        bus.flush   = 1'b0;
        bus.fetched = 1'b0;
        check_eq("mrst_nop",   bus.nop,     1'b1);
        check_eq("mrst_insn",  bus.insn,    32'h0);
        check_eq("mrst_pc",    bus.insn_pc, 30'h0);
        check_eq("mrst_fetch", bus.fetch,   1'b1);
        tick();
        check_eq("mrst_empty_nop", bus.nop, 1'b1);
        bus.fetched    = 1'b1;
        bus.fetch_data = 32'h7000_0007;
        tick();
        bus.fetched = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
        check_eq("mrst_first_insn", bus.insn,    32'h7000_0007);
        check_eq("mrst_first_pc",   bus.insn_pc, 30'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_core_prefetch_queue
